// File: rtl/rider_detect_pkg.sv
// Shared types and constants for the rider detector: SM state encoding, flag bundle, timer terminal counts.
package rider_detect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_STEER = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    typedef struct packed {
        logic sum_gt_min;
        logic sum_lt_min;
        logic diff_gt_1_4;
        logic diff_gt_15_16;
    } flags_t;

    localparam int unsigned TMR_TC_FAST = 16384;
    localparam int unsigned TMR_TC_SLOW = 67_000_000;

endpackage

// File: rtl/rider_detect_if.sv
// Load-cell sample bus: one-cycle strobe plus packed signed samples, cell k at [k*LD_W +: LD_W].
interface rider_detect_if #(
    parameter int NUM_CELLS = 2,
    parameter int LD_W      = 12
);
    logic                          ld_vld;
    logic [NUM_CELLS*LD_W-1:0]     ld_data;

    modport master (output ld_vld, output ld_data);
    modport slave  (input  ld_vld, input  ld_data);
endinterface

// File: rtl/rider_detect_sm.sv
// Rider state machine: Moore outputs from state; fault request overrides every other transition.
// No backpressure; reacts to registered flags one cycle after they are produced.
module rider_detect_sm
    import rider_detect_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  flags_t flags_i,
    input  logic   tmr_full_i,
    input  logic   fault_any_i,
    input  logic   fault_clr_i,
    output logic   tmr_inc_o,
    output logic   en_steer_o,
    output logic   rider_off_o,
    output logic   cell_fault_o
);

    state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (fault_any_i) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (flags_i.sum_gt_min) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    // Imbalance keeps us here with the timer held at zero, even on the full cycle
                    if (flags_i.sum_lt_min)       state_d = ST_IDLE;
                    else if (flags_i.diff_gt_1_4) state_d = ST_WAIT;
                    else if (tmr_full_i)          state_d = ST_STEER;
                end
                ST_STEER: begin
                    if (flags_i.sum_lt_min)         state_d = ST_IDLE;
                    else if (flags_i.diff_gt_15_16) state_d = ST_WAIT;
                end
                ST_FAULT: begin
                    if (fault_clr_i) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        en_steer_o   = (state_q == ST_STEER);
        rider_off_o  = (state_q == ST_IDLE) || (state_q == ST_FAULT);
        cell_fault_o = (state_q == ST_FAULT);
        tmr_inc_o    = (state_q == ST_WAIT) && (state_d == ST_WAIT) && !flags_i.diff_gt_1_4;
    end

endmodule

// File: rtl/rider_detect.sv
// Rider detector: captures load-cell samples, registers weight/balance flags, SM outputs 2 clocks after capture.
// No backpressure: every ld_vld strobe is accepted.
module rider_detect
    import rider_detect_pkg::*;
#(
    parameter int NUM_CELLS    = 2,
    parameter int LD_W         = 12,
    parameter int FAST_SIM     = 1,
    parameter int MIN_RIDER_WT = 512,
    parameter int WT_HYST      = 64,
    parameter int FAULT_SMPLS  = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    rider_detect_if.slave                            ld_if,
    output logic                                     en_steer,
    output logic                                     rider_off,
    output logic                                     cell_fault,
    output logic signed [LD_W+$clog2(NUM_CELLS)-1:0] wt_sum
);

    localparam int          SW     = LD_W + $clog2(NUM_CELLS);
    localparam int          HALF   = NUM_CELLS / 2;
    localparam int unsigned TMR_TC = (FAST_SIM != 0) ? TMR_TC_FAST : TMR_TC_SLOW;
    localparam int          TMR_W  = $clog2(TMR_TC + 1);
    localparam int          FC_W   = $clog2(FAULT_SMPLS + 1);

    localparam logic signed [SW-1:0] THR_HI = SW'(MIN_RIDER_WT + WT_HYST);
    localparam logic signed [SW-1:0] THR_LO = SW'(MIN_RIDER_WT - WT_HYST);
    localparam logic [FC_W-1:0]      FC_MAX = FC_W'(FAULT_SMPLS);

    logic signed [LD_W-1:0] smp_q [NUM_CELLS];
    logic signed [SW-1:0]   sum_c, left_c, right_c, diff_c, abs_c, ext_c;
    flags_t                 flags_d, flags_q;
    logic signed [SW-1:0]   wt_sum_q;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic [FC_W-1:0]        fc_q [NUM_CELLS];
    logic [FC_W-1:0]        fc_d [NUM_CELLS];
    logic                   tmr_inc, tmr_full, fault_any, fault_clr;

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CELLS; k++) begin
            if (rst) begin
                smp_q[k] <= '0;
            end else if (ld_if.ld_vld) begin
                smp_q[k] <= ld_if.ld_data[k*LD_W +: LD_W];
            end
        end
    end

    always_comb begin
        left_c  = '0;
        right_c = '0;
        ext_c   = '0;
        for (int k = 0; k < NUM_CELLS; k++) begin
            ext_c = {{(SW-LD_W){smp_q[k][LD_W-1]}}, smp_q[k]};
            if (k < HALF) left_c  = left_c + ext_c;
            else          right_c = right_c + ext_c;
        end
        sum_c  = left_c + right_c;
        diff_c = left_c - right_c;
        abs_c  = diff_c[SW-1] ? -diff_c : diff_c;

        flags_d.sum_gt_min    = sum_c > THR_HI;
        flags_d.sum_lt_min    = sum_c < THR_LO;
        flags_d.diff_gt_1_4   = abs_c > (sum_c >>> 2);
        flags_d.diff_gt_15_16 = abs_c > (sum_c - (sum_c >>> 4));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q  <= '0;
            wt_sum_q <= '0;
        end else begin
            flags_q  <= flags_d;
            wt_sum_q <= sum_c;
        end
    end

    assign wt_sum   = wt_sum_q;
    assign tmr_full = (tmr_q == TMR_W'(TMR_TC - 1));

    always_comb begin
        tmr_d = '0;
        if (tmr_inc) begin
            tmr_d = (tmr_q == TMR_W'(TMR_TC)) ? tmr_q : tmr_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) tmr_q <= '0;
        else     tmr_q <= tmr_d;
    end

    // Fault counters watch the raw strobe data so the count tracks every sample, not the captured copy
    always_comb begin
        for (int k = 0; k < NUM_CELLS; k++) begin
            fc_d[k] = fc_q[k];
            if (ld_if.ld_vld) begin
                if (!ld_if.ld_data[k*LD_W + LD_W - 1]) fc_d[k] = '0;
                else if (fc_q[k] != FC_MAX)            fc_d[k] = fc_q[k] + FC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CELLS; k++) begin
            if (rst) fc_q[k] <= '0;
            else     fc_q[k] <= fc_d[k];
        end
    end

    always_comb begin
        fault_any = 1'b0;
        fault_clr = 1'b1;
        for (int k = 0; k < NUM_CELLS; k++) begin
            if (fc_q[k] == FC_MAX) fault_any = 1'b1;
            if (fc_q[k] != '0)     fault_clr = 1'b0;
        end
    end

    rider_detect_sm u_sm (
        .clk          (clk),
        .rst          (rst),
        .flags_i      (flags_q),
        .tmr_full_i   (tmr_full),
        .fault_any_i  (fault_any),
        .fault_clr_i  (fault_clr),
        .tmr_inc_o    (tmr_inc),
        .en_steer_o   (en_steer),
        .rider_off_o  (rider_off),
        .cell_fault_o (cell_fault)
    );

endmodule
